// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and key-scan helper for the TM1638 responder.
package tm1638_pkg;

  // Command class, taken from bits [7:6] of the first byte of a frame
  localparam logic [1:0] CLS_DATA = 2'b01;
  localparam logic [1:0] CLS_CTRL = 2'b10;
  localparam logic [1:0] CLS_ADDR = 2'b11;

  // Bit positions inside data and display-control commands
  localparam int DC_READ  = 1;
  localparam int DC_FIXED = 2;
  localparam int CTRL_ON  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  // Key-scan read bit at serial position idx (0..31, LSB first).
  // Byte i carries keys[i] in bit0 and keys[i+4] in bit4; the rest is zero,
  // and every position past the 32nd bit reads as zero.
  function automatic logic key_bit(input logic [7:0] snap, input logic [5:0] idx);
    logic value;
    value = 1'b0;
    if (!idx[5]) begin
      case (idx[2:0])
        3'd0:    value = snap[{1'b0, idx[4:3]}];
        3'd4:    value = snap[{1'b1, idx[4:3]}];
        default: value = 1'b0;
      endcase
    end
    return value;
  endfunction

endpackage

// File: rtl/tm1638_responder_if.sv
// STB/CLK pair of the TM1638 bus; the master owns both, the device only listens.
interface tm1638_responder_if;
  logic sel;
  logic sclk;

  modport master (output sel, output sclk);
  modport slave  (input sel, input sclk);
endinterface

// File: rtl/tm1638_edge_sync.sv
// Multi-flop synchronizer for one asynchronous bus line with rise/fall pulses
// derived from the synchronized value.
module tm1638_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the raw line through the synchronizer and remember the last synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_VALUE}};
      prev  <= RESET_VALUE;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], raw};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/tm1638_responder.sv
// Device side of the TM1638 three-wire bus: decodes data, display-control and
// address commands, holds the 16-byte display RAM and answers key-scan reads.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  tm1638_responder_if.slave   bus,
  inout  wire                 data,
  input  logic [7:0]          keys,
  output logic [127:0]        display_ram,
  output logic                display_on,
  output logic [2:0]          brightness,
  output logic                ram_wr,
  output logic [3:0]          ram_addr,
  output logic                frame_done
);

  state_t      state, state_next;

  logic        sel_sync, sel_rise, sel_fall;
  logic        sclk_sync_unused, sclk_rise, sclk_fall;
  logic        data_sync, data_rise_unused, data_fall_unused;

  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  full_byte;
  logic [3:0]  addr;
  logic        fixed_mode;
  logic [7:0]  key_snap;
  logic [5:0]  rd_idx;
  logic        data_oe;
  logic        data_out;

  logic        active;
  logic        shifting;
  logic        byte_done;
  logic        cmd_done;
  logic        cmd_read;
  logic        rd_step;

  tm1638_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) sel_sync_i (
    .clk(clk), .rst_n(rst_n), .raw(bus.sel),
    .sync(sel_sync), .rise(sel_rise), .fall(sel_fall)
  );

  tm1638_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) sclk_sync_i (
    .clk(clk), .rst_n(rst_n), .raw(bus.sclk),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  tm1638_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) data_sync_i (
    .clk(clk), .rst_n(rst_n), .raw(data),
    .sync(data_sync), .rise(data_rise_unused), .fall(data_fall_unused)
  );

  // Nothing on the bus counts unless the frame select is held low
  assign active    = ~sel_sync;
  assign shifting  = active && sclk_rise &&
                     (state == ST_CMD || state == ST_WDATA || state == ST_IGNORE);
  assign byte_done = shifting && (bit_cnt == 3'd7);
  assign full_byte = {data_sync, shreg};
  assign cmd_done  = byte_done && (state == ST_CMD);
  assign cmd_read  = cmd_done && (full_byte[7:6] == CLS_DATA) && full_byte[DC_READ];
  assign rd_step   = active && sclk_fall && (state == ST_RDATA);

  assign data = data_oe ? data_out : 1'bz;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode: frame boundaries first, then command classification
  always_comb begin
    state_next = state;
    if (sel_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (sel_fall) state_next = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            case (full_byte[7:6])
              CLS_DATA: state_next = full_byte[DC_READ] ? ST_RDATA : ST_IGNORE;
              CLS_CTRL: state_next = ST_IGNORE;
              CLS_ADDR: state_next = ST_WDATA;
              default:  state_next = ST_IGNORE;
            endcase
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Assemble incoming bytes LSB first; alignment restarts at every frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
    end else if (state == ST_IDLE && sel_fall) begin
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
    end else if (shifting) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= full_byte[7:1];
    end
  end

  // Latch write addressing mode and display control from completed commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fixed_mode <= 1'b0;
      display_on <= 1'b0;
      brightness <= 3'd0;
    end else if (cmd_done) begin
      if (full_byte[7:6] == CLS_DATA && !full_byte[DC_READ]) begin
        fixed_mode <= full_byte[DC_FIXED];
      end
      if (full_byte[7:6] == CLS_CTRL) begin
        display_on <= full_byte[CTRL_ON];
        brightness <= full_byte[2:0];
      end
    end
  end

  // Address set and display RAM writes with optional auto-increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= 4'd0;
      display_ram <= '0;
      ram_wr      <= 1'b0;
      ram_addr    <= 4'd0;
    end else begin
      ram_wr <= 1'b0;
      if (cmd_done && full_byte[7:6] == CLS_ADDR) begin
        addr <= full_byte[3:0];
      end else if (byte_done && state == ST_WDATA) begin
        display_ram[{addr, 3'b000} +: 8] <= full_byte;
        ram_wr   <= 1'b1;
        ram_addr <= addr;
        if (!fixed_mode) addr <= addr + 4'd1;
      end
    end
  end

  // Key-scan reply: snapshot keys at the command, then one bit per falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_oe  <= 1'b0;
      data_out <= 1'b0;
      rd_idx   <= 6'd0;
      key_snap <= 8'd0;
    end else if (sel_rise) begin
      data_oe  <= 1'b0;
      data_out <= 1'b0;
    end else if (cmd_read) begin
      key_snap <= keys;
      rd_idx   <= 6'd0;
    end else if (rd_step) begin
      data_oe  <= 1'b1;
      data_out <= key_bit(key_snap, rd_idx);
      if (rd_idx != 6'd32) rd_idx <= rd_idx + 6'd1;
    end
  end

  // One-cycle pulse whenever a frame closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= sel_rise;
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder: directed frames plus randomized
// frames compared against a frame-level model of the panel.
module tb_tm1638_responder;

  logic         clk;
  logic         rst_n;
  logic [7:0]   keys;
  logic [127:0] display_ram;
  logic         display_on;
  logic [2:0]   brightness;
  logic         ram_wr;
  logic [3:0]   ram_addr;
  logic         frame_done;
  logic         tb_oe;
  logic         tb_dout;
  wire          data;

  tm1638_responder_if bus_if ();

  assign data = tb_oe ? tb_dout : 1'bz;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .data(data), .keys(keys),
    .display_ram(display_ram), .display_on(display_on), .brightness(brightness),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] model_ram [16];
  logic       model_on;
  logic [2:0] model_bri;
  logic       model_fixed;

  // Observation counters fed by the monitor
  int         fd_count;
  int         oe_bad;
  logic       read_window;
  logic [3:0] wr_addrs  [$];
  logic [3:0] exp_addrs [$];
  logic [7:0] frame_bytes [$];

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Collect pulses and illegal DIO drive between clock edges
  always @(negedge clk) begin
    if (ram_wr) wr_addrs.push_back(ram_addr);
    if (frame_done) fd_count++;
    if (dut.data_oe && !read_window) oe_bad++;
  end

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++) model_ram[a] = 8'h00;
    model_on    = 1'b0;
    model_bri   = 3'd0;
    model_fixed = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] value, input int count);
    for (int i = 0; i < count; i++) begin
      bus_if.sclk = 1'b0;
      #20;
      tb_oe   = 1'b1;
      tb_dout = value[i];
      #30;
      bus_if.sclk = 1'b1;
      #50;
    end
  endtask

  task automatic read_byte(output logic [7:0] value);
    tb_oe = 1'b0;
    value = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_if.sclk = 1'b0;
      #40;
      value[i] = data;
      #10;
      bus_if.sclk = 1'b1;
      #50;
    end
  endtask

  task automatic start_frame();
    fd_count = 0;
    oe_bad   = 0;
    wr_addrs.delete();
    bus_if.sel = 1'b0;
    #50;
  endtask

  task automatic end_frame();
    #50;
    tb_oe      = 1'b0;
    bus_if.sel = 1'b1;
    #100;
  endtask

  // Compare everything visible after a frame against the model
  task automatic check_frame(input string tag);
    logic [127:0] exp_ram;
    for (int a = 0; a < 16; a++) exp_ram[a*8 +: 8] = model_ram[a];
    check_output({tag, ".ram"}, display_ram, exp_ram);
    check_output({tag, ".on"}, 128'(display_on), 128'(model_on));
    check_output({tag, ".bri"}, 128'(brightness), 128'(model_bri));
    check_output({tag, ".frame_done"}, 128'(fd_count), 128'd1);
    check_output({tag, ".oe_idle"}, 128'(oe_bad), 128'd0);
    check_output({tag, ".wr_count"}, 128'(wr_addrs.size()), 128'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size() && i < wr_addrs.size(); i++)
      check_output({tag, ".wr_addr"}, 128'(wr_addrs[i]), 128'(exp_addrs[i]));
  endtask

  // Drive a write-side frame from frame_bytes (plus optional partial tail)
  task automatic apply_stimulus(input string tag, input int tail_bits, input logic [7:0] tail_val);
    logic [7:0] cmd;
    logic [3:0] a;
    read_window = 1'b0;
    start_frame();
    foreach (frame_bytes[i]) send_bits(frame_bytes[i], 8);
    if (tail_bits > 0) send_bits(tail_val, tail_bits);
    end_frame();
    exp_addrs.delete();
    cmd = frame_bytes[0];
    if (cmd[7:6] == 2'b01 && !cmd[1]) begin
      model_fixed = cmd[2];
    end else if (cmd[7:6] == 2'b10) begin
      model_on  = cmd[3];
      model_bri = cmd[2:0];
    end else if (cmd[7:6] == 2'b11) begin
      a = cmd[3:0];
      for (int i = 1; i < frame_bytes.size(); i++) begin
        model_ram[a] = frame_bytes[i];
        exp_addrs.push_back(a);
        if (!model_fixed) a = a + 4'd1;
      end
    end
    check_frame(tag);
  endtask

  // Key-scan frame: keys change after the command to exercise the snapshot
  task automatic read_frame(input string tag, input logic [7:0] k_cmd, input logic [7:0] k_later);
    logic [7:0] got;
    logic [7:0] expv;
    keys        = k_cmd;
    read_window = 1'b1;
    start_frame();
    send_bits(8'h42, 8);
    keys = k_later;
    for (int b = 0; b < 5; b++) begin
      read_byte(got);
      expv = 8'h00;
      if (b < 4) expv = 8'(k_cmd[b]) | (8'(k_cmd[b+4]) << 4);
      check_output({tag, ".rd_byte"}, 128'(got), 128'(expv));
    end
    end_frame();
    read_window = 1'b0;
    check_output({tag, ".released"}, 128'(dut.data_oe), 128'd0);
    exp_addrs.delete();
    check_frame(tag);
  endtask

  initial begin
    logic [7:0] got;
    int         kind;
    int         nbytes;
    rst_n       = 1'b0;
    bus_if.sel  = 1'b1;
    bus_if.sclk = 1'b1;
    tb_oe       = 1'b0;
    tb_dout     = 1'b0;
    keys        = 8'h00;
    read_window = 1'b0;
    fd_count    = 0;
    oe_bad      = 0;
    model_reset();
    #22;
    check_output("rst.ram", display_ram, 128'd0);
    check_output("rst.on", 128'(display_on), 128'd0);
    check_output("rst.bri", 128'(brightness), 128'd0);
    check_output("rst.ram_wr", 128'(ram_wr), 128'd0);
    check_output("rst.ram_addr", 128'(ram_addr), 128'd0);
    check_output("rst.frame_done", 128'(frame_done), 128'd0);
    check_output("rst.oe", 128'(dut.data_oe), 128'd0);
    rst_n = 1'b1;
    #50;

    frame_bytes = '{8'h8F};
    apply_stimulus("ctrl_8f", 0, 8'h00);

    frame_bytes = '{8'h40};
    apply_stimulus("mode_auto", 0, 8'h00);
    frame_bytes = '{8'hC0, 8'h3F, 8'h06};
    apply_stimulus("write_c0", 0, 8'h00);
    check_output("write_c0.byte0", 128'(display_ram[7:0]), 128'h3F);

    frame_bytes = '{8'h44};
    apply_stimulus("mode_fixed", 0, 8'h00);
    frame_bytes = '{8'hCE, 8'h11, 8'h22};
    apply_stimulus("write_ce_fixed", 0, 8'h00);
    check_output("write_ce_fixed.byte14", 128'(display_ram[119:112]), 128'h22);

    frame_bytes = '{8'h40};
    apply_stimulus("mode_auto2", 0, 8'h00);
    frame_bytes = '{8'hCF, 8'hAA, 8'hBB};
    apply_stimulus("write_wrap", 0, 8'h00);

    read_frame("read_12", 8'b0001_0010, 8'hFF);

    frame_bytes = '{8'hC3};
    apply_stimulus("partial", 5, 8'h5A);

    // Reset in the middle of a key-scan read
    keys        = 8'hA5;
    read_window = 1'b1;
    start_frame();
    send_bits(8'h42, 8);
    read_byte(got);
    check_output("midrd.byte0", 128'(got), 128'h01);
    rst_n = 1'b0;
    #10;
    check_output("midrd.oe_reset", 128'(dut.data_oe), 128'd0);
    check_output("midrd.ram_reset", display_ram, 128'd0);
    bus_if.sel  = 1'b1;
    bus_if.sclk = 1'b1;
    tb_oe       = 1'b0;
    model_reset();
    #20;
    rst_n = 1'b1;
    read_window = 1'b0;
    #50;
    frame_bytes = '{8'h40};
    apply_stimulus("post_rst_mode", 0, 8'h00);
    frame_bytes = '{8'hC0, 8'h5A};
    apply_stimulus("post_rst_write", 0, 8'h00);

    // Randomized frames against the model
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 3));
      frame_bytes.delete();
      if (kind == 0) begin
        frame_bytes.push_back(8'h80 | 8'($urandom_range(0, 15)));
        apply_stimulus("rnd_ctrl", 0, 8'h00);
      end else if (kind == 1) begin
        frame_bytes.push_back(8'h40 | (8'($urandom_range(0, 1)) << 2) | (8'($urandom_range(0, 1)) << 3));
        apply_stimulus("rnd_mode", 0, 8'h00);
      end else if (kind == 2) begin
        frame_bytes.push_back(8'hC0 | 8'($urandom_range(0, 15)));
        nbytes = int'($urandom_range(0, 5));
        for (int i = 0; i < nbytes; i++) frame_bytes.push_back(8'($urandom));
        apply_stimulus("rnd_write", int'($urandom_range(0, 7)), 8'($urandom));
      end else begin
        read_frame("rnd_read", 8'($urandom), 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
